// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the register-file stage and the
// multiply/divide unit. The master drives operations and HI/LO moves; the
// slave (the MDU) returns busy/done and the architectural HI/LO values.
interface mdu_iterative_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              mthi;
  logic              mtlo;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO.
// One iteration per clock: shift-add multiply, restoring divide. Signed ops
// run on magnitudes and the signs are applied in a single FIX cycle.
module mdu_iterative #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mdu_iterative_if.slave bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                is_div;      // latched op[1]
  logic                sign_q;      // negate product / quotient
  logic                sign_r;      // negate remainder
  logic                b_zero;      // divisor was zero
  logic [DATA_W-1:0]   a_raw;       // original dividend for divide-by-zero
  logic [DATA_W-1:0]   opnd;        // multiplicand (mul) or divisor (div)
  // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [2*DATA_W-1:0] acc;
  logic                busy_r, done_r;
  logic [DATA_W-1:0]   hi_r, lo_r;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // Operand conditioning at issue: signed ops (op[0]==0) use magnitudes.
  logic              signed_op, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.operand_a[DATA_W-1];
  assign b_neg     = signed_op & bus.operand_b[DATA_W-1];
  assign a_mag     = a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
  assign b_mag     = b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;

  // Single iteration datapath for both operations.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     rem_sh;
  logic                sub_ok;
  logic [DATA_W-1:0]   rem_sub;
  logic [2*DATA_W-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[DATA_W-1:1]};
    // Bring the next dividend bit (MSB of the low half) into the remainder.
    rem_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    sub_ok   = (rem_sh >= {1'b0, opnd});
    // The difference is always below the divisor, so DATA_W bits suffice.
    rem_sub  = rem_sh[DATA_W-1:0] - opnd;
    div_next = sub_ok ? {rem_sub, acc[DATA_W-2:0], 1'b1}
                      : {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
  end

  // Sign correction applied on the FIX cycle.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

  always_comb begin
    prod_fix = sign_q ? (~acc + 1'b1) : acc;
    quo_fix  = sign_q ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
    rem_fix  = sign_r ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];
    if (!is_div) begin
      hi_fix = prod_fix[2*DATA_W-1:DATA_W];
      lo_fix = prod_fix[DATA_W-1:0];
    end else if (b_zero) begin
      // Quotient bits all set naturally; remainder must be the raw dividend.
      hi_fix = a_raw;
      lo_fix = '1;
    end else begin
      hi_fix = rem_fix;
      lo_fix = quo_fix;
    end
  end

  // Control FSM plus all datapath and HI/LO state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      acc    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[1];
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            b_zero <= (bus.operand_b == '0);
            a_raw  <= bus.operand_a;
            opnd   <= bus.op[1] ? b_mag : a_mag;
            acc    <= {{DATA_W{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= CALC;
          end else begin
            // HI/LO moves only land when no operation is being issued.
            if (bus.mthi) hi_r <= bus.operand_a;
            if (bus.mtlo) lo_r <= bus.operand_a;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W-1)) state <= FIX;
        end
        FIX: begin
          hi_r   <= hi_fix;
          lo_r   <= lo_fix;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: hand-computed MULT/DIV results,
// latency/busy window, HI/LO moves, conflicts, mid-op reset, back-to-back.
module tb_mdu_iterative;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   lat, bcnt, dcnt;

  mdu_iterative_if #(.DATA_W(W)) bus();

  mdu_iterative #(.DATA_W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op for exactly one edge, then scramble the inputs so only
  // the latched values can produce the right answer. Returns just after E0.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = ~op; bus.operand_a = ~a; bus.operand_b = ~b;
  endtask

  // Count cycles until done (bounded) and how many of them had busy high.
  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n, nb;
    issue(op, a, b);
    wait_done(n, nb);
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_busy"}, nb, 33);
    chk({tag, "_hi"}, bus.hi, ehi);
    chk({tag, "_lo"}, bus.lo, elo);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    rst_n = 1'b1;

    run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("busy_after", bus.busy, 0);

    run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run("divu_zero", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run("div_zero_neg", 2'b10, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF);
    run("div_negb", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

    // start + mthi while busy: both ignored
    issue(2'b11, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'hAAAAAAAA;
    bus.operand_b = 32'd3; bus.mthi = 1'b1;
    @(negedge clk);
    chk("busy_mthi_ign", bus.hi, 32'd1);
    bus.start = 1'b0; bus.mthi = 1'b0;
    wait_done(lat, bcnt);
    chk("busy_ign_lat", lat, 23);
    chk("busy_ign_hi", bus.hi, 32'd2);
    chk("busy_ign_lo", bus.lo, 32'd14);

    // idle mtlo
    @(negedge clk);
    bus.operand_a = 32'h55; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.mtlo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h55);
    chk("mtlo_hi", bus.hi, 32'd2);

    // idle start + mthi: start wins
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd9;
    bus.operand_b = 32'd3; bus.mthi = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0;
    chk("start_win_busy", bus.busy, 1);
    chk("start_win_hi", bus.hi, 32'd2);
    wait_done(lat, bcnt);
    chk("start_win_lat", lat, 33);
    chk("start_win_rhi", bus.hi, 32'd0);
    chk("start_win_rlo", bus.lo, 32'd27);

    // reset mid-operation
    issue(2'b01, 32'd5, 32'd5);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);

    // back-to-back: start held through the done cycle
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
    @(negedge clk);
    wait_done(lat, bcnt);
    chk("b2b1_lat", lat, 33);
    chk("b2b1_hi", bus.hi, 32'd0);
    chk("b2b1_lo", bus.lo, 32'd6);
    bus.operand_a = 32'd4; bus.operand_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    chk("b2b2_accept", bus.busy, 1);
    wait_done(lat, bcnt);
    chk("b2b2_lat", lat, 33);
    chk("b2b2_hi", bus.hi, 32'd0);
    chk("b2b2_lo", bus.lo, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
